// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues request/acknowledge data-memory accesses,
// builds byte enables and lane-replicated store data, aligns and extends load
// results, and holds the upstream pipeline while an access is outstanding.
module mem_access_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        extend_sign,
    input  logic [1:0]  wl,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lane_q;
    logic [1:0]       wl_q;
    logic             sign_q;
    logic             access;
    logic             is_misaligned;
    logic             start;

    function automatic logic misaligned_f(input logic [1:0] w, input logic [1:0] a);
        case (w)
            2'b00:   misaligned_f = 1'b0;
            2'b01:   misaligned_f = a[0];
            default: misaligned_f = (a != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] be_f(input logic [1:0] w, input logic [1:0] a);
        case (w)
            2'b00:   be_f = 4'b0001 << a;
            2'b01:   be_f = a[1] ? 4'b1100 : 4'b0011;
            default: be_f = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_f(input logic [1:0] w, input logic [31:0] d);
        case (w)
            2'b00:   wdata_f = {4{d[7:0]}};
            2'b01:   wdata_f = {2{d[15:0]}};
            default: wdata_f = d;
        endcase
    endfunction

    function automatic logic [31:0] load_f(input logic [1:0] w, input logic [1:0] a,
                                           input logic sx, input logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        b = r[{a, 3'b000} +: 8];
        h = a[1] ? r[31:16] : r[15:0];
        case (w)
            2'b00:   load_f = {{24{sx & b[7]}}, b};
            2'b01:   load_f = {{16{sx & h[15]}}, h};
            default: load_f = r;
        endcase
    endfunction

    assign access        = mem_read | mem_write;
    assign is_misaligned = misaligned_f(wl, addr[1:0]);
    assign start         = (state == IDLE) && access && !is_misaligned;

    // Outputs that react to EX/MEM inputs in the same cycle are gated by reset
    // so the pipeline is released the moment reset is applied.
    assign stall    = rst && ((state == REQ) || start);
    assign misalign = rst && (state == IDLE) && access && is_misaligned;
    assign dmem_req = (state == REQ);

    // Access sequencing: latch the request, wait for ack or timeout, then
    // release the pipeline for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            load_data  <= '0;
            bus_err    <= 1'b0;
            lane_q     <= '0;
            wl_q       <= '0;
            sign_q     <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dmem_addr  <= {addr[31:2], 2'b00};
                        dmem_be    <= be_f(wl, addr[1:0]);
                        dmem_wdata <= wdata_f(wl, wdata);
                        dmem_we    <= mem_write;
                        lane_q     <= addr[1:0];
                        wl_q       <= wl;
                        sign_q     <= extend_sign;
                        cnt        <= '0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (dmem_ack) begin
                        if (!dmem_we)
                            load_data <= load_f(wl_q, lane_q, sign_q, dmem_rdata);
                        state <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        bus_err <= 1'b1;
                        if (!dmem_we)
                            load_data <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios followed by randomized
// accesses, checked against a byte-arithmetic reference model.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, dmem_rdata;
    logic        mem_read, mem_write, extend_sign, dmem_ack;
    logic [1:0]  wl;
    logic        dmem_req, dmem_we, stall, misalign, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, load_data;
    logic [3:0]  dmem_be;

    int          passed = 0;
    int          total  = 0;
    int          fails  = 0;
    logic [31:0] exp_ld = '0;

    mem_access_unit #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
        .mem_read(mem_read), .mem_write(mem_write), .extend_sign(extend_sign),
        .wl(wl), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .load_data(load_data), .stall(stall),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_read = 0; mem_write = 0; extend_sign = 0; wl = 0;
        addr = 0; wdata = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    // Reference model: access width in bytes and derived bus values.
    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] w, input logic [31:0] a);
        int n = nbytes(w);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] w, input logic [31:0] d);
        int n = nbytes(w);
        if (n == 1) return (d & 32'hFF) * 32'h01010101;
        if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] w, input logic [31:0] a,
                                             input logic sx, input logic [31:0] r);
        int n = nbytes(w);
        logic [31:0] mask, v;
        if (n == 4) return r;
        mask = (32'h1 << (8 * n)) - 1;
        v = (r >> (8 * (a % 4))) & mask;
        if (sx && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] w, input logic sx,
                       input int dly, input logic [31:0] rdat);
        logic mis;
        logic acked;
        mis = (a % nbytes(w)) != 0;
        mem_read = rd; mem_write = wr; addr = a; wdata = wd; wl = w; extend_sign = sx;
        #1;
        if (mis) begin
            chk("mis_pulse", 32'(misalign), 1);
            chk("mis_stall", 32'(stall), 0);
            chk("mis_req", 32'(dmem_req), 0);
            step();
            clear_inputs();
            #1;
            chk("mis_after", 32'(misalign), 0);
            chk("mis_req_after", 32'(dmem_req), 0);
            chk("mis_ld_kept", load_data, exp_ld);
            return;
        end
        chk("idle_stall", 32'(stall), 1);
        chk("idle_misalign", 32'(misalign), 0);
        chk("idle_req", 32'(dmem_req), 0);
        step();
        clear_inputs();
        acked = 0;
        for (int k = 0; k < TMO; k++) begin
            chk("req_high", 32'(dmem_req), 1);
            chk("req_stall", 32'(stall), 1);
            chk("req_addr", dmem_addr, a & 32'hFFFF_FFFC);
            chk("req_be", 32'(dmem_be), 32'(ref_be(w, a)));
            chk("req_we", 32'(dmem_we), 32'(wr));
            if (wr) chk("req_wdata", dmem_wdata, ref_wdata(w, wd));
            if (k == dly) begin
                dmem_ack = 1; dmem_rdata = rdat; acked = 1;
            end
            step();
            dmem_ack = 0; dmem_rdata = $urandom;
            if (acked) break;
        end
        if (rd && !wr) exp_ld = acked ? ref_load(w, a, sx, rdat) : 32'h0;
        chk("done_req", 32'(dmem_req), 0);
        chk("done_stall", 32'(stall), 0);
        chk("done_bus_err", 32'(bus_err), 32'(!acked));
        chk("done_load", load_data, exp_ld);
        // EX/MEM contents and a stray ack presented in DONE must be ignored
        mem_read = 1; wl = 2'b10; addr = $urandom & 32'hFFFF_FFFC;
        dmem_ack = 1; dmem_rdata = $urandom;
        #1;
        chk("done_ignore_stall", 32'(stall), 0);
        step();
        clear_inputs();
        #1;
        chk("idle_req_low", 32'(dmem_req), 0);
        chk("idle_bus_err", 32'(bus_err), 0);
        chk("idle_stall_low", 32'(stall), 0);
        chk("idle_load_kept", load_data, exp_ld);
    endtask

    initial begin
        clear_inputs();
        rst = 0;
        mem_read = 1; wl = 2'b10; addr = 32'h100;
        #1;
        chk("rst_stall", 32'(stall), 0);
        step();
        step();
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_we", 32'(dmem_we), 0);
        chk("rst_be", 32'(dmem_be), 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_load", load_data, 0);
        chk("rst_misalign", 32'(misalign), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        clear_inputs();
        rst = 1;
        step();

        // Word load, ack in second REQ cycle
        txn(1, 0, 32'h100, 32'h0, 2'b10, 0, 1, 32'hDEADBEEF);
        chk("word_load_const", load_data, 32'hDEADBEEF);
        // Byte loads, sign- and zero-extended
        txn(1, 0, 32'h103, 32'h0, 2'b00, 1, 0, 32'h80FFFFFF);
        chk("byte_sx_const", load_data, 32'hFFFFFF80);
        txn(1, 0, 32'h103, 32'h0, 2'b00, 0, 2, 32'h80FFFFFF);
        chk("byte_zx_const", load_data, 32'h00000080);
        // Half store in upper half
        txn(0, 1, 32'h22, 32'h1234ABCD, 2'b01, 0, 0, 32'h0);
        chk("half_store_ld_kept", load_data, 32'h00000080);
        // Misaligned word load
        txn(1, 0, 32'h102, 32'h0, 2'b10, 0, 0, 32'h0);
        // No ack: timeout
        txn(1, 0, 32'h200, 32'h0, 2'b10, 0, 99, 32'h0);
        chk("timeout_ld_zero", load_data, 32'h0);

        // Reset during REQ, then a late ack
        txn(1, 0, 32'h44, 32'h0, 2'b10, 0, 0, 32'h5555AAAA);
        mem_read = 1; wl = 2'b10; addr = 32'h40;
        step();
        clear_inputs();
        #1;
        chk("pre_rst_req", 32'(dmem_req), 1);
        rst = 0;
        #1;
        chk("midrst_req", 32'(dmem_req), 0);
        chk("midrst_stall", 32'(stall), 0);
        chk("midrst_be", 32'(dmem_be), 0);
        chk("midrst_addr", dmem_addr, 0);
        chk("midrst_load", load_data, 0);
        exp_ld = 0;
        step();
        rst = 1;
        step();
        dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
        #1;
        chk("late_ack_req", 32'(dmem_req), 0);
        chk("late_ack_stall", 32'(stall), 0);
        step();
        dmem_ack = 0;
        #1;
        chk("late_ack_load", load_data, 32'h0);
        chk("late_ack_req2", 32'(dmem_req), 0);

        // Randomized accesses
        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            txn(kind != 1, kind != 0, 32'h2000 + 32'($urandom_range(0, 63)), $urandom,
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 5), $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
